// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver: FSM encoding and the
// default widths/latencies that the edge detector alignment also depends on.
package serial_word_receiver_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WORD_WIDTH = 8;
  // 2-flop synchronizer plus output register in the edge detector
  localparam int SYNC_LATENCY = 3;

endpackage

// File: rtl/serial_word_receiver_bit_delay_line.sv
// DEPTH-stage 1-bit delay line with synchronous reset; DEPTH=0 is a wire.
module bit_delay_line
  import serial_word_receiver_pkg::*;
#(
  parameter int DEPTH = SYNC_LATENCY
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_d
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = i_clk ^ i_rst;
      assign o_d = i_d;
    end else begin : g_shift
      logic [DEPTH-1:0] r_stage;

      // shift the data bit one stage per clock
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_stage <= '0;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_d = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/serial_word_receiver.sv
// Assembles sampled serial bits into words inside a frame and hands them to
// the consumer over valid/ready, flagging partial frames and dropped words.
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int DATA_DELAY = SYNC_LATENCY
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst,
  input  logic                  i_bit_edge,
  input  logic                  i_frame_active,
  input  logic                  i_data_in,
  output logic [WORD_WIDTH-1:0] o_word_out,
  output logic                  o_word_valid,
  input  logic                  i_word_ready,
  output logic                  o_frame_end,
  output logic                  o_partial,
  output logic                  o_overrun,
  input  logic                  i_overrun_clr
);

  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_WIDTH - 1);

  state_e                r_state;
  state_e                w_state_next;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [WORD_WIDTH-1:0] r_shreg;
  logic [WORD_WIDTH-1:0] w_word_next;
  logic [WORD_WIDTH-1:0] r_word_out;
  logic                  r_word_valid;
  logic                  r_frame_end;
  logic                  r_partial;
  logic                  r_overrun;
  logic                  w_d;
  logic                  w_shift_en;
  logic                  w_close;
  logic                  w_complete;
  logic                  w_accept;

  bit_delay_line #(.DEPTH(DATA_DELAY)) u_delay (
    .i_clk (i_sys_clk),
    .i_rst (i_rst),
    .i_d   (i_data_in),
    .o_d   (w_d)
  );

  // FSM state register
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: a dropped frame enable always forces one IDLE cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  w_state_next = i_frame_active ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: w_state_next = i_frame_active ? ST_SHIFT : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: strobes are honoured only while shifting inside a frame
  always_comb begin
    w_shift_en = 1'b0;
    w_close    = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        w_shift_en = i_frame_active & i_bit_edge;
        w_close    = ~i_frame_active;
      end
      ST_IDLE: begin
        w_shift_en = 1'b0;
        w_close    = 1'b0;
      end
      default: begin
        w_shift_en = 1'b0;
        w_close    = 1'b0;
      end
    endcase
  end

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_word_next = {r_shreg[WORD_WIDTH-2:0], w_d};
    end else begin : g_lsb
      assign w_word_next = {w_d, r_shreg[WORD_WIDTH-1:1]};
    end
  endgenerate

  assign w_complete = w_shift_en & (r_bit_cnt == CNT_LAST);
  assign w_accept   = w_complete & (~r_word_valid | i_word_ready);

  // bit counter and shift register; cleared outside a frame so no stale bits leak
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else if (w_close || (r_state == ST_IDLE)) begin
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else if (w_shift_en) begin
      r_bit_cnt <= w_complete ? '0 : r_bit_cnt + CNT_W'(1);
      r_shreg   <= w_word_next;
    end
  end

  // word hand-off: a completed word is dropped if the consumer is stalling
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
    end else if (w_accept) begin
      r_word_out   <= w_word_next;
      r_word_valid <= 1'b1;
    end else if (r_word_valid && i_word_ready) begin
      r_word_valid <= 1'b0;
    end
  end

  // frame-close pulse, partial flag and sticky overrun (set beats clear)
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_frame_end <= 1'b0;
      r_partial   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_end <= w_close;
      r_partial   <= w_close & (r_bit_cnt != '0);
      if (w_complete && !w_accept) begin
        r_overrun <= 1'b1;
      end else if (i_overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_word_out   = r_word_out;
  assign o_word_valid = r_word_valid;
  assign o_frame_end  = r_frame_end;
  assign o_partial    = r_partial;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench: directed frame table, hand-written corner sequences and
// a randomized run, all shadowed by a frame-level reference model.
module tb_serial_word_receiver;

  localparam int W  = 8;
  localparam int DD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_edge = 1'b0;
  logic frame_active = 1'b0;
  logic data_in = 1'b0;
  logic word_ready = 1'b0;
  logic overrun_clr = 1'b0;

  logic [W-1:0] wo_m, wo_l;
  logic wv_m, fe_m, pa_m, ov_m;
  logic wv_l, fe_l, pa_l, ov_l;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_word_receiver #(.WORD_WIDTH(W), .MSB_FIRST(1'b1), .DATA_DELAY(DD)) dut_m (
    .i_sys_clk(clk), .i_rst(rst), .i_bit_edge(bit_edge), .i_frame_active(frame_active),
    .i_data_in(data_in), .o_word_out(wo_m), .o_word_valid(wv_m), .i_word_ready(word_ready),
    .o_frame_end(fe_m), .o_partial(pa_m), .o_overrun(ov_m), .i_overrun_clr(overrun_clr));

  serial_word_receiver #(.WORD_WIDTH(W), .MSB_FIRST(1'b0), .DATA_DELAY(DD)) dut_l (
    .i_sys_clk(clk), .i_rst(rst), .i_bit_edge(bit_edge), .i_frame_active(frame_active),
    .i_data_in(data_in), .o_word_out(wo_l), .o_word_valid(wv_l), .i_word_ready(word_ready),
    .o_frame_end(fe_l), .o_partial(pa_l), .o_overrun(ov_l), .i_overrun_clr(overrun_clr));

  // Reference model: bits of the open frame are kept as a list, a word is
  // formed once W bits are collected, and data_in is seen DD edges late.
  bit           m_in_frame = 1'b0;
  bit           m_bits[$];
  logic         m_dq[$];
  logic [W-1:0] m_word_m = '0;
  logic [W-1:0] m_word_l = '0;
  logic         m_valid = 1'b0;
  logic         m_fe = 1'b0;
  logic         m_partial = 1'b0;
  logic         m_ovr = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_update();
    logic d;
    logic completed;
    logic close;
    logic [W-1:0] wm, wl;
    if (rst) begin
      m_dq.delete();
      for (int i = 0; i < DD; i++) m_dq.push_back(1'b0);
      m_in_frame = 1'b0; m_bits.delete();
      m_word_m = '0; m_word_l = '0; m_valid = 1'b0;
      m_fe = 1'b0; m_partial = 1'b0; m_ovr = 1'b0;
      return;
    end
    if (DD == 0) d = data_in;
    else begin
      d = m_dq.pop_front();
      m_dq.push_back(data_in);
    end
    close = m_in_frame && !frame_active;
    completed = 1'b0;
    wm = '0; wl = '0;
    if (m_in_frame && frame_active && bit_edge) begin
      m_bits.push_back(d);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = m_bits[i];
          wl[i] = m_bits[i];
        end
        m_bits.delete();
        completed = 1'b1;
      end
    end
    m_fe = close;
    m_partial = close && (m_bits.size() != 0);
    if (close) m_bits.delete();
    if (completed && m_valid && !word_ready) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
    if (completed && (!m_valid || word_ready)) begin
      m_word_m = wm; m_word_l = wl; m_valid = 1'b1;
    end else if (!completed && m_valid && word_ready) begin
      m_valid = 1'b0;
    end
    m_in_frame = frame_active;
  endtask

  task automatic compare_model();
    check("model.msb.word_out", 32'(wo_m), 32'(m_word_m));
    check("model.msb.word_valid", 32'(wv_m), 32'(m_valid));
    check("model.msb.frame_end", 32'(fe_m), 32'(m_fe));
    check("model.msb.partial", 32'(pa_m), 32'(m_partial));
    check("model.msb.overrun", 32'(ov_m), 32'(m_ovr));
    check("model.lsb.word_out", 32'(wo_l), 32'(m_word_l));
    check("model.lsb.word_valid", 32'(wv_l), 32'(m_valid));
    check("model.lsb.frame_end", 32'(fe_l), 32'(m_fe));
    check("model.lsb.partial", 32'(pa_l), 32'(m_partial));
    check("model.lsb.overrun", 32'(ov_l), 32'(m_ovr));
  endtask

  // One clock: predict, clock the DUTs, then compare on the falling edge.
  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  // Hold the bit long enough to clear the delay line, then strobe it.
  task automatic send_bit(input logic b);
    data_in = b;
    repeat (DD) step();
    bit_edge = 1'b1;
    step();
    bit_edge = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] seq);
    for (int b = W - 1; b >= 0; b--) send_bit(seq[b]);
  endtask

  typedef struct {
    logic [7:0] seq;
    int         nbits;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
    logic       exp_partial;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] s;
    vecs[0] = '{seq: 8'hA5, nbits: 8, exp_msb: 8'hA5, exp_lsb: 8'hA5, exp_partial: 1'b0};
    vecs[1] = '{seq: 8'h80, nbits: 8, exp_msb: 8'h80, exp_lsb: 8'h01, exp_partial: 1'b0};
    vecs[2] = '{seq: 8'hF8, nbits: 5, exp_msb: 8'h80, exp_lsb: 8'h01, exp_partial: 1'b1};
    vecs[3] = '{seq: 8'hFF, nbits: 8, exp_msb: 8'hFF, exp_lsb: 8'hFF, exp_partial: 1'b0};
    vecs[4] = '{seq: 8'h5A, nbits: 8, exp_msb: 8'h5A, exp_lsb: 8'h5A, exp_partial: 1'b0};

    rst = 1'b1;
    step(); step();
    check("reset.word_out", 32'(wo_m), 32'd0);
    check("reset.word_valid", 32'(wv_m), 32'd0);
    check("reset.overrun", 32'(ov_m), 32'd0);
    rst = 1'b0;
    step();

    // Directed frames with an always-ready consumer
    word_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      frame_active = 1'b1;
      step();
      s = vecs[k].seq;
      for (int b = 0; b < vecs[k].nbits; b++) send_bit(s[7-b]);
      if (vecs[k].nbits == 8) begin
        check("tbl.valid_after_word", 32'(wv_m), 32'd1);
      end else begin
        check("tbl.no_valid_partial", 32'(wv_m), 32'd0);
      end
      check("tbl.msb.word", 32'(wo_m), 32'(vecs[k].exp_msb));
      check("tbl.lsb.word", 32'(wo_l), 32'(vecs[k].exp_lsb));
      frame_active = 1'b0;
      step();
      check("tbl.frame_end", 32'(fe_m), 32'd1);
      check("tbl.partial", 32'(pa_m), 32'(vecs[k].exp_partial));
      check("tbl.valid_cleared", 32'(wv_m), 32'd0);
      step();
      check("tbl.frame_end_one_cycle", 32'(fe_m), 32'd0);
    end

    // Stalled consumer: second word is dropped, overrun set then cleared
    word_ready = 1'b0;
    frame_active = 1'b1;
    step();
    send_word(8'h3C);
    check("ovr.first_word", 32'(wo_m), 32'h3C);
    check("ovr.first_valid", 32'(wv_m), 32'd1);
    send_word(8'hC3);
    check("ovr.word_held", 32'(wo_m), 32'h3C);
    check("ovr.flag_set", 32'(ov_m), 32'd1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr.flag_cleared", 32'(ov_m), 32'd0);
    word_ready = 1'b1;
    step();
    check("ovr.valid_consumed", 32'(wv_m), 32'd0);

    // Completion in the same cycle the pending word is consumed
    word_ready = 1'b0;
    send_word(8'h12);
    check("same.first_lsb", 32'(wo_l), 32'h48);
    s = 8'h34;
    for (int b = 7; b >= 1; b--) send_bit(s[b]);
    data_in = s[0];
    repeat (DD) step();
    word_ready = 1'b1;
    bit_edge = 1'b1;
    step();
    bit_edge = 1'b0;
    check("same.msb.word", 32'(wo_m), 32'h34);
    check("same.lsb.word", 32'(wo_l), 32'h2C);
    check("same.valid", 32'(wv_m), 32'd1);
    check("same.no_overrun", 32'(ov_m), 32'd0);
    step();

    // Reset in the middle of a frame
    for (int b = 0; b < 4; b++) send_bit(b[0]);
    rst = 1'b1;
    step();
    check("rst.word_out", 32'(wo_m), 32'd0);
    check("rst.valid", 32'(wv_m), 32'd0);
    check("rst.frame_end", 32'(fe_m), 32'd0);
    rst = 1'b0;
    frame_active = 1'b0;
    step();
    check("rst.no_frame_end", 32'(fe_m), 32'd0);
    frame_active = 1'b1;
    step();
    send_word(8'h5A);
    check("rst.after_word", 32'(wo_m), 32'h5A);
    frame_active = 1'b0;
    step();

    // Strobes outside a frame are ignored
    for (int i = 0; i < 6; i++) begin
      data_in = 1'b1;
      bit_edge = 1'b1;
      step();
      check("idle.no_frame_end", 32'(fe_m), 32'd0);
    end
    bit_edge = 1'b0;
    frame_active = 1'b1;
    step();
    send_word(8'h96);
    check("idle.msb.word", 32'(wo_m), 32'h96);
    check("idle.lsb.word", 32'(wo_l), 32'h69);
    frame_active = 1'b0;
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 24) == 0) frame_active = ~frame_active;
      bit_edge = ($urandom_range(0, 2) == 0);
      data_in = $urandom_range(0, 1);
      word_ready = ($urandom_range(0, 3) != 0) ? ~word_ready : word_ready;
      overrun_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    rst = 1'b0;
    bit_edge = 1'b0;
    overrun_clr = 1'b0;
    frame_active = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Consumes the single-cycle sample strobes produced by the edge detector and a synchronized frame-enable, such as inverted chip select.
- Shifts the data line into WORD_WIDTH-bit words and delivers each completed word over a valid/ready handshake to the MITM logic downstream.
- Tracks frame boundaries, reports partial trailing words, and flags overruns when the consumer stalls.

Parameters:
- WORD_WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 means the first sampled bit lands in word_out[WORD_WIDTH-1]; 0 means the first sampled bit lands in word_out[0].
- DATA_DELAY, 3: sys_clk cycles of delay applied to data_in so it aligns with bit_edge. This matches the edge detector's 2-flop synchronizer plus its output register.

Ports:
- sys_clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- bit_edge  input  1  one-cycle sample strobe from the edge detector.
- frame_active  input  1  synchronized frame enable, active-high.
- data_in  input  1  synchronized serial data line, not yet delayed.
- word_out  output  WORD_WIDTH  last completed word.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out this cycle.
- frame_end  output  1  one-cycle pulse when a frame closes.
- partial  output  1  qualified by frame_end: the closed frame ended mid-word.
- overrun  output  1  sticky: a completed word was dropped.
- overrun_clr  input  1  clears overrun.

Behaviour:
- Reset: applies on a sys_clk rising edge while rst=1.
  - All outputs are cleared to 0, including word_out.
  - Internal state cleared: delay line, shift register, bit counter, FSM (enters IDLE).
  - Reset asserted mid-frame discards any partial word and produces no frame_end.
- Delay line: data_in passes through a DATA_DELAY-stage shift register, reset to 0. The shift register samples only the delayed bit d. DATA_DELAY=0 means d=data_in.
- FSM states:
  - IDLE:
    - bit_edge is ignored.
    - frame_active=1 moves to SHIFT with bit_cnt=0.
  - SHIFT, while frame_active=1, on each bit_edge:
    - MSB_FIRST=1: shreg <= {shreg[W-2:0], d}.
    - MSB_FIRST=0: shreg <= {d, shreg[W-1:1]}.
    - bit_cnt increments.
  - Word completion: bit_edge arrives with bit_cnt==W-1.
    - The assembled word, including the current bit, becomes the completed word.
    - bit_cnt wraps to 0 and the FSM stays in SHIFT.
  - SHIFT, frame_active=0 in any cycle:
    - Next cycle: frame_end=1 for exactly one cycle.
    - partial=(bit_cnt!=0) in that same cycle.
    - FSM returns to IDLE.
    - A bit_edge in the same cycle as frame_active=0 is ignored.
- Word delivery: latency is 1 cycle. word_valid rises on the cycle after the completing bit_edge.
  - Completed word when word_valid=0, or word_valid=1 with word_ready=1: word_out loads the word and word_valid=1.
  - Completed word when word_valid=1 and word_ready=0: the word is discarded, word_out is unchanged, and overrun is set.
  - word_valid=1 with word_ready=1 and no new word that cycle: word_valid clears.
  - word_ready while word_valid=0 has no effect.
  - word_out is stable whenever word_valid=1 and word_ready=0.
- overrun:
  - Cleared by overrun_clr.
  - A set condition in the same cycle as overrun_clr wins; overrun stays 1.
  - overrun is not cleared by frame boundaries.
- frame_active dropping and returning in consecutive cycles yields two frames. The FSM must pass through IDLE for at least one cycle.
- A pending word_valid persists across frame_end and IDLE until consumed.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, SHIFT).
  - Default word width constant (8).
  - Default synchronizer latency constant (3), referenced by DATA_DELAY and the edge detector alignment.
- One natural sub-module, bit_delay_line: a parameterized DATA_DELAY-stage 1-bit shift register with synchronous reset. Everything else stays in serial_word_receiver.

Test Plan:
- MSB_FIRST=1, W=8, word_ready=1, one frame of bits 1,0,1,0,0,1,0,1 (0xA5):
  - word_out=0xA5 with word_valid high one cycle after the 8th bit_edge.
  - frame_end=1 with partial=0 after frame_active falls.
- MSB_FIRST=0, same bit sequence: word_out=0xA5 reversed, i.e. 0xA5 → 0xA5 bit-reversed = 0xA5 (symmetric), so rerun with 0x01 sent as 1,0,0,0,0,0,0,0 → word_out=0x01.
- word_ready=0, two back-to-back words 0x3C then 0xC3:
  - word_out stays 0x3C and overrun=1.
  - overrun_clr pulse → overrun=0.
  - word_ready=1 → word_valid clears next cycle.
- Frame closed after 5 bit_edges:
  - frame_end pulse with partial=1 and no word_valid.
  - Next frame of 8 bits 0xFF → word_out=0xFF (no stale bits).
- Same-cycle word completion and word_ready=1 with word_valid=1: new word loads, word_valid stays 1, overrun stays 0.
- rst asserted after 4 bits of a frame:
  - All outputs 0 and no frame_end.
  - After release, a full frame of 0x5A → word_out=0x5A.
  - bit_edge with frame_active=0 never changes state.
